muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the pipeline's HI/LO multiply/divide unit, sitting beside the EX stage. It accepts MULT/MULTU/DIV/DIVU from EX and runs a fixed-latency multiply or a 32-iteration restoring divide. It owns the HI/LO registers and services MTHI/MTLO. It raises a combinational stall toward PC/IF-ID write-enable and the ID/EX bubble whenever an instruction in ID touches HI/LO before the result is ready.

## Interface
- MUL_LAT, 4, multiply latency in cycles (>=1); Busy stays high this many cycles per multiply
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- EX_Start  in  1  valid mult/div in EX this cycle
- EX_Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- EX_A, EX_B  in  32  rs / rt operands (dividend / divisor for divides)
- EX_MTHI, EX_MTLO  in  1  move-to-HI/LO in EX
- EX_WriteData  in  32  data for MTHI/MTLO
- ID_HiLoAccess  in  1  instruction in ID is MFHI/MFLO/MTHI/MTLO or mult/div
- Busy  out  1  operation in flight (registered)
- Done  out  1  one-cycle pulse, first cycle new HI/LO are visible
- Stall  out  1  (Busy | EX_Start) & ID_HiLoAccess, combinational
- HI, LO  out  32  architectural HI/LO registers

## Operation
- States: IDLE, MUL, DIV, SIGN.
- Reset: state IDLE, HI=LO=0, Busy=0, Done=0, counter=0, all internal operand and remainder registers 0.
- IDLE, EX_Start, MULT/MULTU: latch the 64-bit product (signed or unsigned) into a holding register, load counter with MUL_LAT-1, go to MUL.
- MUL: decrement counter. At 0, write {HI,LO}=product, pulse Done next cycle, go to IDLE.
- IDLE, EX_Start, DIV/DIVU with EX_B!=0: latch |A| and |B| (DIVU: raw), record quotient sign (A^B sign bits) and remainder sign (A sign), counter=31, go to DIV.
- DIV: one restoring step per cycle (shift remainder:quotient left by 1, trial-subtract divisor, set quotient bit if non-negative). At counter 0 go to SIGN.
- SIGN: negate quotient and remainder per the recorded signs (DIVU: none), write LO=quotient and HI=remainder, go to IDLE.
- Divide by zero: no iteration. LO=32'hFFFFFFFF and HI=EX_A are written after one Busy cycle, then IDLE.
- MTHI/MTLO in IDLE without EX_Start: write EX_WriteData to HI/LO at the next edge. There is no Busy and no Done.
- EX_Start, EX_MTHI or EX_MTLO while Busy: ignored, and flagged by a simulation assertion. Stall prevents this case.
- Same-cycle EX_Start and EX_MTHI/EX_MTLO: EX_Start wins.
- Arithmetic: all 64-bit intermediate values are unsigned internally. Signed handling happens only at operand latch (multiply sign-extends to 64) and in SIGN.
- DIV of 32'h80000000 by -1: yields LO=32'h80000000, HI=0, which is the wrap result of the magnitude path.

## Timing
- EX_Start is sampled at the edge ending cycle T.
- Multiply: Busy=1 during cycles T+1..T+MUL_LAT. New HI/LO and Done=1 appear at T+MUL_LAT+1.
- Divide: Busy=1 for 33 cycles, T+1..T+33 (32 DIV + 1 SIGN). HI/LO and Done appear at T+34.
- Divide by zero: Busy during T+1. Result and Done appear at T+2.
- MTHI/MTLO: visible at T+1.
- Stall is high in cycle T itself when ID_HiLoAccess=1, and drops in the Done cycle. An MFHI/MFLO released that cycle reads the new value.
- Reset mid-operation: the next cycle shows the reset values above. Any in-flight result is discarded and Done is not asserted.

## Structure
- Shared package muldiv_pkg holds:
  - the EX_Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state encoding (S_IDLE, S_MUL, S_DIV, S_SIGN);
  - DIV_ITERS=32.
- One sub-module: div_step, the combinational single restoring iteration. Inputs are remainder, quotient and divisor (32 each); outputs are the next remainder and next quotient. It is instantiated once in the DIV state.

## Test plan
- MULT A=-3, B=7, MUL_LAT=4 -> Busy high for 4 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, Done pulse at T+5.
- DIVU A=100, B=7 -> Busy 33 cycles, LO=14, HI=2 at T+34; DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIV A=5, B=0 -> Busy 1 cycle, LO=32'hFFFFFFFF, HI=5 at T+2.
- MULTU in EX with MFLO in ID at T -> Stall=1 from T until the Done cycle. In the Done cycle Stall=0 and LO holds the product.
- MTLO 32'h1234 while idle -> LO=32'h1234 next cycle, Busy=0, Done=0.
- DIV started, Reset asserted at T+10 -> T+11: IDLE, Busy=0, HI=LO=0, Done never pulses.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: EX opcodes,
// FSM state, and the divide iteration count.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_SIGN = 2'd3
    } state_e;

    // Two's-complement magnitude; 32'h80000000 maps to itself, read as 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-divide iteration: shift remainder:quotient left by one,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic [31:0] next_quo
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;

    // rem < divisor holds between steps, so shifted < 2*divisor and bit 32
    // of the difference is a clean borrow flag.
    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, divisor};
    assign ge       = ~diff[32];
    assign next_rem = ge ? diff[31:0] : shifted[31:0];
    assign next_quo = {quo[30:0], ge};

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer beside EX: fixed-latency multiply,
// 32-step restoring divide, MTHI/MTLO, and the ID-side HI/LO hazard stall.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        EX_Start,
    input  logic [1:0]  EX_Op,
    input  logic [31:0] EX_A,
    input  logic [31:0] EX_B,
    input  logic        EX_MTHI,
    input  logic        EX_MTLO,
    input  logic [31:0] EX_WriteData,
    input  logic        ID_HiLoAccess,
    output logic        Busy,
    output logic        Done,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output state_e      dbg_state
);

    localparam int CNT_W = 8;

    state_e             state;
    logic [CNT_W-1:0]   counter;
    logic [63:0]        product;
    logic [31:0]        rem;
    logic [31:0]        quo;
    logic [31:0]        divisor;
    logic               q_neg;
    logic               r_neg;
    logic               is_signed_div;
    logic [31:0]        step_rem;
    logic [31:0]        step_quo;

    assign Stall         = (Busy | EX_Start) & ID_HiLoAccess;
    assign dbg_state     = state;
    assign is_signed_div = (EX_Op == OP_DIV);

    div_step u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            counter <= '0;
            product <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (EX_Start) begin
                        Busy <= 1'b1;
                        if (EX_Op == OP_MULT) begin
                            product <= {{32{EX_A[31]}}, EX_A} * {{32{EX_B[31]}}, EX_B};
                            counter <= CNT_W'(MUL_LAT - 1);
                            state   <= S_MUL;
                        end else if (EX_Op == OP_MULTU) begin
                            product <= {32'd0, EX_A} * {32'd0, EX_B};
                            counter <= CNT_W'(MUL_LAT - 1);
                            state   <= S_MUL;
                        end else if (EX_B == 32'd0) begin
                            // Divide by zero skips iteration; SIGN just publishes.
                            quo   <= 32'hFFFF_FFFF;
                            rem   <= EX_A;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= S_SIGN;
                        end else begin
                            quo     <= is_signed_div ? abs32(EX_A) : EX_A;
                            divisor <= is_signed_div ? abs32(EX_B) : EX_B;
                            rem     <= '0;
                            q_neg   <= is_signed_div & (EX_A[31] ^ EX_B[31]);
                            r_neg   <= is_signed_div & EX_A[31];
                            counter <= CNT_W'(DIV_ITERS - 1);
                            state   <= S_DIV;
                        end
                    end else begin
                        if (EX_MTHI) HI <= EX_WriteData;
                        if (EX_MTLO) LO <= EX_WriteData;
                    end
                end
                S_MUL: begin
                    if (counter == '0) begin
                        {HI, LO} <= product;
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                S_DIV: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    if (counter == '0) state <= S_SIGN;
                    else counter <= counter - 1'b1;
                end
                S_SIGN: begin
                    LO    <= q_neg ? (~quo + 32'd1) : quo;
                    HI    <= r_neg ? (~rem + 32'd1) : rem;
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // New work while busy would be silently dropped; Stall must prevent it.
    a_no_issue_while_busy: assert property (
        @(posedge Clk) disable iff (Reset) Busy |-> !(EX_Start || EX_MTHI || EX_MTLO)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer with an expected-result queue
// checked at each Done pulse.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        EX_Start = 1'b0;
    logic [1:0]  EX_Op = 2'b00;
    logic [31:0] EX_A = '0;
    logic [31:0] EX_B = '0;
    logic        EX_MTHI = 1'b0;
    logic        EX_MTLO = 1'b0;
    logic [31:0] EX_WriteData = '0;
    logic        ID_HiLoAccess = 1'b0;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    state_e      dbg_state;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_hilo = '0;

    muldiv_sequencer #(.MUL_LAT(MUL_LAT)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .EX_Start      (EX_Start),
        .EX_Op         (EX_Op),
        .EX_A          (EX_A),
        .EX_B          (EX_B),
        .EX_MTHI       (EX_MTHI),
        .EX_MTLO       (EX_MTLO),
        .EX_WriteData  (EX_WriteData),
        .ID_HiLoAccess (ID_HiLoAccess),
        .Busy          (Busy),
        .Done          (Done),
        .Stall         (Stall),
        .HI            (HI),
        .LO            (LO),
        .dbg_state     (dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference result {HI, LO} from the language's own arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sp;
        int     q, r;
        logic [63:0] res;
        res = '0;
        if (op == OP_MULT) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            sp  = sa * sb;
            res = sp;
        end else if (op == OP_MULTU) begin
            res = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (op == OP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res = {32'd0, 32'h8000_0000};
            end else begin
                q   = $signed(a) / $signed(b);
                r   = $signed(a) % $signed(b);
                res = {r, q};
            end
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic id, input logic mt);
        int          lat;
        int          n;
        logic [63:0] exp;
        lat = (op[1] == 1'b0) ? MUL_LAT + 1 : ((b == 32'd0) ? 2 : 34);
        exp_q.push_back(model(op, a, b));
        EX_Start      = 1'b1;
        EX_Op         = op;
        EX_A          = a;
        EX_B          = b;
        ID_HiLoAccess = id;
        EX_MTHI       = mt;
        EX_MTLO       = mt;
        EX_WriteData  = 32'hDEAD_BEEF;
        #1;
        chk("stall_at_start", 64'(Stall), 64'(id));
        tick();
        EX_Start = 1'b0;
        EX_MTHI  = 1'b0;
        EX_MTLO  = 1'b0;
        n = 1;
        while (Done !== 1'b1 && n < 100) begin
            chk("busy_in_flight", 64'(Busy), 64'd1);
            if (id) chk("stall_in_flight", 64'(Stall), 64'd1);
            tick();
            n++;
        end
        chk("done_latency", 64'(n), 64'(lat));
        chk("busy_at_done", 64'(Busy), 64'd0);
        chk("stall_at_done", 64'(Stall), 64'd0);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk("hilo_result", {HI, LO}, exp);
            last_hilo = exp;
        end
        tick();
        chk("done_one_cycle", 64'(Done), 64'd0);
        ID_HiLoAccess = 1'b0;
    endtask

    initial begin
        int   done_seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tick();
        tick();
        Reset = 1'b0;
        chk("reset_hi", 64'(HI), 64'd0);
        chk("reset_lo", 64'(LO), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(S_IDLE));
        chk("reset_stall", 64'(Stall), 64'd0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op(OP_MULT, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);

        EX_MTLO      = 1'b1;
        EX_WriteData = 32'h0000_1234;
        tick();
        EX_MTLO = 1'b0;
        chk("mtlo_lo", 64'(LO), 64'h1234);
        chk("mtlo_hi_kept", 64'(HI), 64'(last_hilo[63:32]));
        chk("mtlo_busy", 64'(Busy), 64'd0);
        chk("mtlo_done", 64'(Done), 64'd0);
        EX_MTHI      = 1'b1;
        EX_WriteData = 32'hCAFE_F00D;
        tick();
        EX_MTHI = 1'b0;
        chk("mthi_hi", 64'(HI), 64'hCAFE_F00D);
        chk("mthi_lo_kept", 64'(LO), 64'h1234);
        chk("mthi_done", 64'(Done), 64'd0);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        EX_Start = 1'b1;
        EX_Op    = OP_DIV;
        EX_A     = 32'd1000;
        EX_B     = 32'd3;
        tick();
        EX_Start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midreset_state", 64'(dbg_state), 64'(S_IDLE));
        chk("midreset_busy", 64'(Busy), 64'd0);
        chk("midreset_hi", 64'(HI), 64'd0);
        chk("midreset_lo", 64'(LO), 64'd0);
        chk("midreset_done", 64'(Done), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) done_seen++;
            tick();
        end
        chk("midreset_no_done", 64'(done_seen), 64'd0);
        chk("midreset_lo_held", 64'(LO), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
